// File: rtl/spi_config_bank.sv
// SPI (mode 0) addressed bank of shadow/active configuration registers for the VGA GPU.
// Optional burst mode with address auto-increment: define SPI_AUTOINC_EN.
module spi_config_bank #(
   parameter int               N_REGS          = 8,
   parameter int               REG_W           = 32,
   parameter logic [REG_W-1:0] RST_REG0        = REG_W'(32'hBBFC0000),
   parameter bit               UPDATE_ON_FRAME = 1'b1
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic                      sclk,
   input  logic                      mosi,
   input  logic                      ss_n,
   output logic                      miso,
   input  logic                      frame_start,
   output logic [N_REGS*REG_W-1:0]   config_flat,
   output logic                      busy,
   output logic                      err
);

   localparam int AW = (N_REGS > 1) ? $clog2(N_REGS) : 1;
   localparam int CW = $clog2(REG_W);
`ifdef SPI_AUTOINC_EN
   localparam bit AUTOINC = 1'b1;
`else
   localparam bit AUTOINC = 1'b0;
`endif

   typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DRAIN} state_t;

   state_t           r_state, w_next;
   logic [2:0]       r_sclk_s, r_ss_s;
   logic [1:0]       r_mosi_s, r_fill;
   logic             r_armed;
   logic [CW-1:0]    r_bitcnt;
   logic [REG_W-1:0] r_rx, r_tx;
   logic             r_wr, r_miso, r_err, r_commit;
   logic [6:0]       r_addr, r_commit_addr;
   logic [REG_W-1:0] r_shadow [N_REGS];
   logic [REG_W-1:0] w_active [N_REGS];

   logic       w_sclk_rise, w_sclk_fall, w_ss_rise, w_ss_fall, w_mosi;
   logic [7:0] w_cmd;
   logic       w_addr_ok, w_cmd_done, w_word_done;
   logic [6:0] w_next_addr;
   logic       w_shift_en, w_tx_drive, w_commit_set, w_err_set;

   // Select is only honoured after it has been seen high once since reset, so a
   // transfer interrupted by reset is ignored until ss_n is released.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sclk_s <= '0;
         r_ss_s   <= '1;
         r_mosi_s <= '0;
         r_fill   <= '0;
         r_armed  <= 1'b0;
      end else begin
         r_sclk_s <= {r_sclk_s[1:0], sclk};
         r_ss_s   <= {r_ss_s[1:0], ss_n};
         r_mosi_s <= {r_mosi_s[0], mosi};
         r_fill   <= {r_fill[0], 1'b1};
         r_armed  <= r_armed | (r_fill[1] & r_ss_s[1]);
      end
   end

   assign w_sclk_rise = r_sclk_s[1] & ~r_sclk_s[2];
   assign w_sclk_fall = ~r_sclk_s[1] & r_sclk_s[2];
   assign w_ss_rise   = r_ss_s[1] & ~r_ss_s[2];
   assign w_ss_fall   = r_armed & r_ss_s[2] & ~r_ss_s[1];
   assign w_mosi      = r_mosi_s[1];
   assign busy        = r_fill[1] & ~r_ss_s[1];

   assign w_cmd       = {r_rx[6:0], w_mosi};
   assign w_addr_ok   = ({1'b0, w_cmd[6:0]} < 8'(N_REGS));
   assign w_cmd_done  = (r_state == S_CMD)  && w_sclk_rise && (r_bitcnt == CW'(7));
   assign w_word_done = (r_state == S_DATA) && w_sclk_rise && (r_bitcnt == CW'(REG_W-1));
   assign w_next_addr = (r_addr == 7'(N_REGS-1)) ? 7'd0 : r_addr + 7'd1;

   always_ff @(posedge clk) begin
      if (!rst_n) r_state <= S_IDLE;
      else        r_state <= w_next;
   end

   always_comb begin
      w_next = r_state;
      if (w_ss_rise) begin
         w_next = S_IDLE;
      end else begin
         case (r_state)
            S_IDLE:  if (w_ss_fall) w_next = S_CMD;
            S_CMD:   if (w_cmd_done) w_next = w_addr_ok ? S_DATA : S_DRAIN;
            S_DATA:  if (w_word_done && !AUTOINC) w_next = S_DRAIN;
            default: w_next = r_state;
         endcase
      end
   end

   always_comb begin
      w_shift_en   = w_sclk_rise && ((r_state == S_CMD) || (r_state == S_DATA));
      w_tx_drive   = w_sclk_fall && (r_state == S_DATA) && !r_wr;
      w_commit_set = w_word_done && r_wr && !w_ss_rise;
      w_err_set    = w_cmd_done && !w_addr_ok && !w_ss_rise;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_bitcnt      <= '0;
         r_rx          <= '0;
         r_tx          <= '0;
         r_wr          <= 1'b0;
         r_addr        <= '0;
         r_miso        <= 1'b0;
         r_err         <= 1'b0;
         r_commit      <= 1'b0;
         r_commit_addr <= '0;
      end else begin
         if ((r_state == S_IDLE) && w_ss_fall)  r_bitcnt <= '0;
         else if (w_cmd_done || w_word_done)    r_bitcnt <= '0;
         else if (w_shift_en)                   r_bitcnt <= r_bitcnt + CW'(1);

         if (w_shift_en) r_rx <= {r_rx[REG_W-2:0], w_mosi};

         if (w_cmd_done) begin
            r_wr   <= w_cmd[7];
            r_addr <= w_cmd[6:0];
         end else if (w_word_done && AUTOINC) begin
            r_addr <= w_next_addr;
         end

         // Read data is staged at the last command rise so the MSB leaves on the following fall.
         if (w_cmd_done)
            r_tx <= (w_addr_ok && !w_cmd[7]) ? r_shadow[w_cmd[AW-1:0]] : '0;
         else if (w_word_done && !r_wr)
            r_tx <= r_shadow[w_next_addr[AW-1:0]];
         else if (w_tx_drive)
            r_tx <= {r_tx[REG_W-2:0], 1'b0};

         if ((r_state != S_DATA) || r_wr) r_miso <= 1'b0;
         else if (w_tx_drive)             r_miso <= r_tx[REG_W-1];

         r_commit      <= w_commit_set;
         r_commit_addr <= r_addr;
         r_err         <= w_err_set;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < N_REGS; i++) r_shadow[i] <= (i == 0) ? RST_REG0 : '0;
      end else if (r_commit) begin
         r_shadow[r_commit_addr[AW-1:0]] <= r_rx;
      end
   end

   generate
      if (UPDATE_ON_FRAME) begin : g_frame
         logic [REG_W-1:0] r_active [N_REGS];
         // Non-blocking copy: a commit in the same clk as frame_start waits for the next frame.
         always_ff @(posedge clk) begin
            if (!rst_n) begin
               for (int i = 0; i < N_REGS; i++) r_active[i] <= (i == 0) ? RST_REG0 : '0;
            end else if (frame_start) begin
               r_active <= r_shadow;
            end
         end
         assign w_active = r_active;
      end else begin : g_direct
         assign w_active = r_shadow;
      end
   endgenerate

   always_comb begin
      config_flat = '0;
      for (int i = 0; i < N_REGS; i++) config_flat[i*REG_W +: REG_W] = w_active[i];
   end

   assign miso = r_miso;
   assign err  = r_err;

endmodule
